// File: rtl/matrix_pkg.sv
// Shared types and default dimensions for the MAC control/array and its result drain.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FIN
  } drain_state_t;

  localparam int unsigned MAC_SIZE   = 16;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned RES_ADDR_W = 8;

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready write channel from the result drain to the result memory.
interface result_drain_if
  import matrix_pkg::*;
#(
  parameter int unsigned WIDTH  = ACC_WIDTH,
  parameter int unsigned ADDR_W = RES_ADDR_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/result_drain.sv
// Snapshots SIZE accumulator lanes on done_in and streams them to result memory,
// one word per accepted handshake, at consecutive (wrapping) addresses.
module result_drain
  import matrix_pkg::*;
#(
  parameter int unsigned SIZE   = MAC_SIZE,
  parameter int unsigned WIDTH  = ACC_WIDTH,
  parameter int unsigned ADDR_W = RES_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_in,
  input  logic [SIZE*WIDTH-1:0]   acc_in,
  input  logic [ADDR_W-1:0]       base_addr,
  result_drain_if.master          res,
  output logic                    acc_clr,
  output logic                    busy,
  output logic                    drained,
  output logic                    overrun
);

  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  drain_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  snap_q [SIZE];
  logic [WIDTH-1:0]  snap_d [SIZE];
  logic [ADDR_W-1:0] base_q, base_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              drn_q, drn_d;
  logic              ovr_q, ovr_d;
  logic              xfer;

  assign xfer = valid_q && res.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    base_d  = base_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    clr_d   = 1'b0;
    busy_d  = busy_q;
    drn_d   = 1'b0;
    ovr_d   = ovr_q;

    unique case (state_q)
      DRAIN: begin
        // A done_in here only flags overrun; the snapshot being drained is untouched.
        if (done_in) ovr_d = 1'b1;
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
            valid_d = 1'b0;
            data_d  = '0;
            addr_d  = '0;
            drn_d   = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = snap_q[idx_d];
            addr_d = base_q + ADDR_W'(idx_d);
          end
        end
      end
      default: begin
        // IDLE and FIN both accept a new operation; FIN otherwise falls back to IDLE.
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        addr_d  = '0;
        busy_d  = 1'b0;
        if (done_in) begin
          for (int unsigned i = 0; i < SIZE; i++) begin
            snap_d[i] = acc_in[i*WIDTH +: WIDTH];
          end
          base_d  = base_addr;
          idx_d   = '0;
          state_d = DRAIN;
          valid_d = 1'b1;
          data_d  = acc_in[WIDTH-1:0];
          addr_d  = base_addr;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '{default: '0};
      base_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      drn_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      drn_q   <= drn_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res.out_valid = valid_q;
  assign res.out_data  = data_q;
  assign res.out_addr  = addr_q;
  assign acc_clr       = clr_q;
  assign busy          = busy_q;
  assign drained       = drn_q;
  assign overrun       = ovr_q;

endmodule
